fsm_prog_ring: RTL
==================

FSM_PROG_RING -- requirements
Module: fsm_prog_ring

Parameters
REQ-001 SHALL provide parameter N, default 7: number of states, legal range 2..16.
REQ-002 SHALL provide parameter W, default 3: state-code width in bits.
REQ-003 SHALL provide parameter T, default 4: dwell-counter width in bits.
REQ-004 SHALL use IW = max(1, clog2(N)) as the state-index width.

Interface
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  global step enable for the state and counter logic.
REQ-008 go  input  N  per-state advance request; bit k guards the exit from state k.
REQ-009 jmp  input  1  forced jump request.
REQ-010 jmp_idx  input  IW  jump target index.
REQ-011 cfg_we  input  1  configuration write strobe.
REQ-012 cfg_addr  input  IW  configuration table entry to write.
REQ-013 cfg_code  input  W  state code to store in the addressed entry.
REQ-014 cfg_dwell  input  T  minimum dwell to store in the addressed entry.
REQ-015 y  output  W  code of the current state, driven as code[idx].
REQ-016 idx  output  IW  current state index, registered.
REQ-017 cnt  output  T  cycles spent in the current state, registered.
REQ-018 wrap  output  1  registered one-cycle pulse on the transition N-1 -> 0.

Function
REQ-019 SHALL hold two tables of N entries each: code[k] (W bits) and dwell[k] (T bits).
REQ-020 SHALL track the state by index; y SHALL be combinational from idx and the code table.
REQ-021 Advance condition: en & go[idx] & (cnt >= dwell[idx]).
REQ-022 On advance, next idx SHALL be idx+1, or 0 when idx = N-1.
REQ-023 On advance, cnt SHALL be cleared to 0.
REQ-024 Jump condition: en & jmp & (jmp_idx < N). When it holds, idx <= jmp_idx and cnt <= 0, regardless of the go input.
REQ-025 A jump SHALL override a simultaneous advance.
REQ-026 A jump with jmp_idx >= N SHALL be ignored, and normal advance evaluation SHALL still apply in that cycle.
REQ-027 A jump to the current index SHALL still clear cnt.
REQ-028 With en high and no state change, cnt SHALL increment by 1.
REQ-029 cnt SHALL saturate at 2^T-1 and SHALL NOT wrap.
REQ-030 With en low, idx, cnt and wrap SHALL hold, except that wrap SHALL drop to 0 after one cycle.
REQ-031 wrap SHALL be 1 for exactly the cycle following an advance from N-1 to 0.
REQ-032 A jump to index 0 SHALL NOT assert wrap.
REQ-033 cfg_we SHALL be independent of en: code[cfg_addr] <= cfg_code and dwell[cfg_addr] <= cfg_dwell.
REQ-034 A write with cfg_addr >= N SHALL be ignored.
REQ-035 A config write in the same cycle as an advance evaluation SHALL NOT affect that evaluation, which uses the pre-write dwell value.
REQ-036 A written entry SHALL be visible on y and in the dwell compare from the next cycle.
REQ-037 With all dwell entries 0, go[k] held high and en held high, the block SHALL advance every cycle (N=7 reproduces the legacy 7-state ring).

Reset
REQ-038 On reset: idx=0, cnt=0, wrap=0, code[k]=k mod 2^W, dwell[k]=0; y therefore reads 0 in the cycle after reset.
REQ-039 Reset SHALL take priority over jmp, advance and cfg_we in the same cycle.
REQ-040 Reset asserted mid-dwell SHALL discard the count and any pending transition.

Verification
REQ-041 Bench SHALL cover the following (N=7, W=3, T=4):
- Reset, then en=1, go=7'h7F for 7 cycles -> idx steps 1..6,0; wrap=1 only in the cycle idx returns to 0; y tracks idx.
- Write dwell[2]=3, go[2]=1 held; enter state 2 -> stays 4 cycles (cnt 0..3), advances with cnt=3; idx=3 and cnt=0 next cycle.
- Write code[0..6]=5,3,6,1,7,2,4; step the ring -> y sequence 5,3,6,1,7,2,4,5.
- jmp=1, jmp_idx=5 while advance is also valid from idx 1 -> idx=5, cnt=0; then jmp_idx=7 -> ignored, advance applies.
- en=0 for 20 cycles at dwell[1]=15 -> idx and cnt frozen; with en=1, cnt saturates at 15 and does not wrap.
- Reset in the same cycle as cfg_we to addr 0 with code 6 -> y=0 and code[0]=0 afterwards.

Source files
------------

// File: rtl/fsm_prog_ring.sv
// Programmable N-state ring sequencer with per-state output code and minimum dwell.
// Latency: idx/cnt/wrap update one clock after the qualifying inputs; y follows idx combinationally.
// Backpressure: none; en stalls the ring, and config writes proceed regardless of en.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   en                  step enable for idx/cnt/wrap
//   go[N]               per-state advance request, bit k guards the exit from state k
//   jmp, jmp_idx        forced jump (ignored when jmp_idx >= N)
//   cfg_we, cfg_addr,   table write: code[cfg_addr] <= cfg_code,
//   cfg_code, cfg_dwell            dwell[cfg_addr] <= cfg_dwell (ignored when cfg_addr >= N)
//   y                   code of the current state
//   idx, cnt            current state index and saturating dwell count
//   wrap                one-cycle pulse after advancing from N-1 to 0
module fsm_prog_ring #(
  parameter int N  = 7,
  parameter int W  = 3,
  parameter int T  = 4,
  parameter int IW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  go,
  input  logic          jmp,
  input  logic [IW-1:0] jmp_idx,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_code,
  input  logic [T-1:0]  cfg_dwell,
  output logic [W-1:0]  y,
  output logic [IW-1:0] idx,
  output logic [T-1:0]  cnt,
  output logic          wrap
);

  logic [W-1:0]  code_q  [N];
  logic [T-1:0]  dwell_q [N];
  logic [IW-1:0] idx_q, idx_d;
  logic [T-1:0]  cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  logic jump_ok;
  logic adv_ok;
  logic cfg_ok;
  logic at_last;

  // Out-of-range jump targets and config addresses are dropped here so that
  // idx never leaves 0..N-1 and the tables are never written past their end.
  assign jump_ok = en & jmp & (32'(jmp_idx) < N);
  assign cfg_ok  = cfg_we & (32'(cfg_addr) < N);
  // The dwell compare reads the registered table, so a same-cycle write
  // cannot influence this cycle's decision.
  assign adv_ok  = en & go[idx_q] & (cnt_q >= dwell_q[idx_q]);
  assign at_last = (idx_q == IW'(N - 1));

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (jump_ok) begin
      // Jump wins over advance and never signals a wrap, even to index 0.
      idx_d = jmp_idx;
      cnt_d = '0;
    end else if (adv_ok) begin
      idx_d  = at_last ? '0 : idx_q + IW'(1);
      cnt_d  = '0;
      wrap_d = at_last;
    end else if (en) begin
      cnt_d = (cnt_q == {T{1'b1}}) ? cnt_q : cnt_q + T'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        code_q[k]  <= W'(k);
        dwell_q[k] <= '0;
      end
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      if (cfg_ok) begin
        code_q[cfg_addr]  <= cfg_code;
        dwell_q[cfg_addr] <= cfg_dwell;
      end
    end
  end

  assign y    = code_q[idx_q];
  assign idx  = idx_q;
  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule
